// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer and its multiplier.
package mat_pkg;

  // Sequencer phases: operand load, multiplier pipeline fill, result drain.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Number of enabled multiplier cycles needed to fill the adder tree.
  function automatic int unsigned fill_cycles(input int unsigned n);
    int unsigned d;
    d = $clog2(n);
    return (d > 1) ? d : 1;
  endfunction

  // Operand / result shapes of the default configuration (N=2, W_IN=8, W_OUT=32).
  typedef logic [1:0][1:0][7:0]  mat_op_t;
  typedef logic [1:0][1:0][31:0] mat_res_t;

endpackage

// File: rtl/mat_serializer.sv
// NE-to-1 result serializer with a registered valid/ready output stage.
module mat_serializer #(
  parameter int unsigned W_OUT = 32,
  parameter int unsigned NE    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NE-1:0][W_OUT-1:0]     result,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [W_OUT-1:0]      out_data,
  output logic                         out_last,
  output logic                         done_c
);

  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_inc_c;

  assign idx_inc_c = idx_q + IW'(1);
  assign done_c    = out_valid & out_ready & out_last;

  // Present element 0 on start, advance one element per accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (start) begin
      idx_q     <= '0;
      out_valid <= 1'b1;
      out_data  <= result[0];
      out_last  <= (NE == 1);
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        idx_q     <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx_q    <= idx_inc_c;
        out_data <= result[idx_inc_c];
        out_last <= (idx_inc_c == IW'(NE - 1));
      end
    end
  end

endmodule

// File: rtl/mat_mul_seq.sv
// Sequencer feeding a pipelined NxN matrix multiplier from an element stream
// and draining its result as a stream.
// Optional build macro MAT_MUL_SEQ_OVERLAP_EN: buffer the result so the next
// operand pair loads while the current result drains.
module mat_mul_seq
  import mat_pkg::*;
#(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = 32,
  parameter int unsigned N     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [W_IN-1:0]        in_data,
  output logic [N-1:0][N-1:0][W_IN-1:0] mm_matrix_1,
  output logic [N-1:0][N-1:0][W_IN-1:0] mm_matrix_2,
  output logic                          mm_cen,
  input  logic [N-1:0][N-1:0][W_OUT-1:0] mm_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [W_OUT-1:0]       out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned NE   = N * N;
  localparam int unsigned FILL = fill_cycles(N);
  localparam int unsigned CW   = $clog2(2 * NE + 1);
  localparam int unsigned FW   = $clog2(FILL + 1);

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [FW-1:0] fill_q, fill_nx;
  logic          in_ready_nx, mm_cen_nx, busy_nx;

  logic                     accept_c;
  logic                     fill_last_c;
  logic                     drain_done_c;
  logic [NE-1:0][W_OUT-1:0] ser_src_c;

  assign accept_c    = in_valid & in_ready;
  assign fill_last_c = (state_q == COMPUTE) && (fill_q == FW'(FILL - 1));

  // Next state, counters and next values of the registered control outputs.
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    fill_nx     = fill_q;
    in_ready_nx = 1'b0;
    mm_cen_nx   = 1'b0;
    busy_nx     = 1'b1;

    if (accept_c) cnt_nx = cnt_q + CW'(1);

    case (state_q)
      LOAD: begin
        if (accept_c && (cnt_q == CW'(2 * NE - 1))) state_nx = COMPUTE;
      end
      COMPUTE: begin
        if (fill_last_c) begin
          state_nx = DRAIN;
          fill_nx  = '0;
          cnt_nx   = '0;
        end else begin
          fill_nx = fill_q + FW'(1);
        end
      end
      DRAIN: begin
        if (drain_done_c) begin
`ifdef MAT_MUL_SEQ_OVERLAP_EN
          state_nx = (cnt_nx == CW'(2 * NE)) ? COMPUTE : LOAD;
`else
          state_nx = LOAD;
          cnt_nx   = '0;
`endif
        end
      end
      default: begin
        state_nx = LOAD;
        cnt_nx   = '0;
        fill_nx  = '0;
      end
    endcase

`ifdef MAT_MUL_SEQ_OVERLAP_EN
    in_ready_nx = (state_nx == LOAD) ||
                  ((state_nx == DRAIN) && (cnt_nx != CW'(2 * NE)));
`else
    in_ready_nx = (state_nx == LOAD);
`endif
    mm_cen_nx = (state_nx == COMPUTE);
    busy_nx   = !((state_nx == LOAD) && (cnt_nx == '0));
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      fill_q   <= '0;
      in_ready <= 1'b0;
      mm_cen   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      fill_q   <= fill_nx;
      in_ready <= in_ready_nx;
      mm_cen   <= mm_cen_nx;
      busy     <= busy_nx;
    end
  end

  // Operand registers: element k lands in matrix k/NE at row-major slot k%NE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_matrix_1 <= '0;
      mm_matrix_2 <= '0;
    end else if (accept_c) begin
      for (int e = 0; e < int'(NE); e++) begin
        if (cnt_q == CW'(e))      mm_matrix_1[e / int'(N)][e % int'(N)] <= in_data;
        if (cnt_q == CW'(NE + e)) mm_matrix_2[e / int'(N)][e % int'(N)] <= in_data;
      end
    end
  end

`ifdef MAT_MUL_SEQ_OVERLAP_EN
  logic [NE-1:0][W_OUT-1:0] res_buf_q;

  // Snapshot the product on the final enabled cycle so operands may reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_buf_q <= '0;
    else if (fill_last_c) res_buf_q <= mm_result;
  end

  assign ser_src_c = (state_q == DRAIN) ? res_buf_q : mm_result;
`else
  assign ser_src_c = mm_result;
`endif

  mat_serializer #(
    .W_OUT (W_OUT),
    .NE    (NE)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (fill_last_c),
    .result    (ser_src_c),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done_c    (drain_done_c)
  );

endmodule

// File: tb/tb_mat_mul_seq.sv
// Self-checking bench for mat_mul_seq (N=2 and N=4 instances, ideal multiplier model).
module tb_mat_mul_seq;

  localparam int unsigned W_IN  = 8;
  localparam int unsigned W_OUT = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=2 instance
  logic                         in_valid, in_ready, mm_cen, out_valid, out_ready, out_last, busy;
  logic signed [W_IN-1:0]       in_data;
  logic [1:0][1:0][W_IN-1:0]    mm_matrix_1, mm_matrix_2;
  logic [1:0][1:0][W_OUT-1:0]   mm_result;
  logic signed [W_OUT-1:0]      out_data;

  // N=4 instance
  logic                         in_valid_4, in_ready_4, mm_cen_4, out_valid_4, out_ready_4, out_last_4, busy_4;
  logic signed [W_IN-1:0]       in_data_4;
  logic [3:0][3:0][W_IN-1:0]    mm_matrix_1_4, mm_matrix_2_4;
  logic [3:0][3:0][W_OUT-1:0]   mm_result_4;
  logic signed [W_OUT-1:0]      out_data_4;

  mat_mul_seq #(.W_IN(W_IN), .W_OUT(W_OUT), .N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_matrix_1(mm_matrix_1), .mm_matrix_2(mm_matrix_2), .mm_cen(mm_cen),
    .mm_result(mm_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy));

  mat_mul_seq #(.W_IN(W_IN), .W_OUT(W_OUT), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .in_data(in_data_4),
    .mm_matrix_1(mm_matrix_1_4), .mm_matrix_2(mm_matrix_2_4), .mm_cen(mm_cen_4),
    .mm_result(mm_result_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .out_data(out_data_4), .out_last(out_last_4), .busy(busy_4));

  // Ideal multiplier: product of whatever operands the sequencer presents.
  always_comb begin : mul2
    int s;
    s = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'($signed(mm_matrix_1[r][k])) * int'($signed(mm_matrix_2[k][c]));
        mm_result[r][c] = W_OUT'(s);
      end
  end

  always_comb begin : mul4
    int s;
    s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'($signed(mm_matrix_1_4[r][k])) * int'($signed(mm_matrix_2_4[k][c]));
        mm_result_4[r][c] = W_OUT'(s);
      end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference 2x2 product on row-major integer arrays.
  function automatic void ref_mul2(input int a[4], input int b[4], output int c[4]);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        c[i*2+j] = a[i*2] * b[j] + a[i*2+1] * b[2+j];
  endfunction

  typedef struct {
    int a[4];
    int b[4];
    int c[4];
    bit bp;
  } vec_t;

  vec_t vecs[4];

  // Load one 2x2 pair, drain the product; out_ready follows 1,0,0,1 when bp is set.
  task automatic run2(input int a[4], input int b[4], input int c[4], input bit bp, input string tag);
    int vals[8];
    int k, got, cen, t_acc0, t_acc7, t_first, t_last, drain_rdy;
    bit stalled;
    logic signed [W_OUT-1:0] held;
    for (int i = 0; i < 4; i++) begin vals[i] = a[i]; vals[i+4] = b[i]; end
    k = 0; got = 0; cen = 0; t_acc0 = -1; t_acc7 = -1; t_first = -1; t_last = -1;
    drain_rdy = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && got < 4; cyc++) begin
      @(negedge clk);
      if (stalled) check({tag, "_stall_hold"}, out_data, held);
      if (mm_cen) cen++;
      if (out_valid && t_first < 0) t_first = cyc;
      if (out_valid && in_ready) drain_rdy++;
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        check($sformatf("%s_data%0d", tag, got), out_data, c[got]);
        check($sformatf("%s_last%0d", tag, got), out_last, (got == 3));
        if (got == 3) t_last = cyc;
        got++;
      end
      if (k < 8) begin
        in_valid = 1'b1;
        in_data  = W_IN'(vals[k]);
        if (in_ready) begin
          if (k == 0) t_acc0 = cyc;
          if (k == 7) t_acc7 = cyc;
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, "_count"}, got, 4);
    check({tag, "_latency"}, t_first - t_acc7, 2);
    check({tag, "_cen_cycles"}, cen, 1);
`ifndef MAT_MUL_SEQ_OVERLAP_EN
    check({tag, "_in_ready_in_drain"}, drain_rdy, 0);
`endif
    if (!bp) check({tag, "_throughput"}, t_last - t_acc0 + 1, 13);
    @(negedge clk);
    check({tag, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
  endtask

  // N=4: identity times (-8..7) must reproduce B row-major.
  task automatic run4();
    int vals[32];
    int k, got, cen, t_acc, t_first, n_last, last_idx;
    for (int i = 0; i < 16; i++) begin
      vals[i]    = (i / 4 == i % 4) ? 1 : 0;
      vals[16+i] = i - 8;
    end
    k = 0; got = 0; cen = 0; t_acc = -1; t_first = -1; n_last = 0; last_idx = -1;
    out_ready_4 = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      if (mm_cen_4) cen++;
      if (out_valid_4 && t_first < 0) t_first = cyc;
      if (out_valid_4) begin
        check($sformatf("n4_data%0d", got), out_data_4, got - 8);
        if (out_last_4) begin n_last++; last_idx = got; end
        got++;
      end
      if (k < 32) begin
        in_valid_4 = 1'b1;
        in_data_4  = W_IN'(vals[k]);
        if (in_ready_4) begin
          if (k == 31) t_acc = cyc;
          k++;
        end
      end else begin
        in_valid_4 = 1'b0;
      end
    end
    in_valid_4 = 1'b0;
    check("n4_count", got, 16);
    check("n4_cen_cycles", cen, 2);
    check("n4_latency", t_first - t_acc, 3);
    check("n4_last_pulses", n_last, 1);
    check("n4_last_index", last_idx, 15);
  endtask

`ifdef MAT_MUL_SEQ_OVERLAP_EN
  // Second pair streams in while the first result is held in DRAIN.
  task automatic overlap2();
    int vals[16];
    int exp_v[8];
    int k, got, t_last1, t_cen2, ovl_acc;
    for (int i = 0; i < 4; i++) begin
      vals[i] = vecs[0].a[i]; vals[4+i] = vecs[0].b[i];
      vals[8+i] = vecs[2].a[i]; vals[12+i] = vecs[2].b[i];
      exp_v[i] = vecs[0].c[i]; exp_v[4+i] = vecs[2].c[i];
    end
    k = 0; got = 0; t_last1 = -1; t_cen2 = -1; ovl_acc = 0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      if (mm_cen && t_last1 >= 0 && t_cen2 < 0) t_cen2 = cyc;
      out_ready = (k >= 16);
      if (out_valid && out_ready) begin
        check($sformatf("ovl_data%0d", got), out_data, exp_v[got]);
        if (got == 3) t_last1 = cyc;
        got++;
      end
      if (k < 16) begin
        in_valid = 1'b1;
        in_data  = W_IN'(vals[k]);
        if (in_ready) begin
          if (out_valid) ovl_acc++;
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("ovl_count", got, 8);
    check("ovl_loaded_in_drain", ovl_acc, 8);
    check("ovl_compute_start", t_cen2 - t_last1, 1);
    @(negedge clk);
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    int k;
    int ra[4], rb[4], rc[4];
    logic signed [W_OUT-1:0] first_val;

    vecs[0] = '{'{1, 2, 3, 4},         '{5, 6, 7, 8},   '{19, 22, 43, 50},       1'b0};
    vecs[1] = '{'{-128, -128, 127, 0}, '{-128, 0, 1, 0}, '{16256, 0, -16256, 0}, 1'b0};
    vecs[2] = '{'{2, -1, 0, 3},        '{4, 5, -6, 7},   '{14, 3, -18, 21},       1'b0};
    vecs[3] = '{'{1, 2, 3, 4},         '{5, 6, 7, 8},   '{19, 22, 43, 50},       1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid_4 = 1'b0; in_data_4 = '0; out_ready_4 = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  in_ready,  0);
    check("rst_mm_cen",    mm_cen,    0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_busy",      busy,      0);
    check("rst_operands",  {mm_matrix_1, mm_matrix_2}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors
    for (int v = 0; v < 4; v++)
      run2(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].bp, $sformatf("vec%0d", v));

    // Randomized products against the reference
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = int'($urandom_range(0, 255)) - 128;
        rb[i] = int'($urandom_range(0, 255)) - 128;
      end
      ref_mul2(ra, rb, rc);
      run2(ra, rb, rc, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    // Reset after five accepted inputs
    k = 0;
    for (int cyc = 0; cyc < 50 && k < 5; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W_IN'(k + 9);
      if (in_ready) k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_load_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_load_rst_in_ready", in_ready, 0);
    check("mid_load_rst_busy", busy, 0);
    check("mid_load_rst_operands", {mm_matrix_1, mm_matrix_2}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    run2(vecs[0].a, vecs[0].b, vecs[0].c, 1'b0, "after_rst");

    // Long stall in DRAIN, then reset while output is pending
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 60 && !out_valid; cyc++) begin
      @(negedge clk);
      if (k < 8) begin
        in_valid = 1'b1;
        in_data  = W_IN'(k < 4 ? vecs[0].a[k] : vecs[0].b[k-4]);
        if (in_ready) k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    first_val = out_data;
    repeat (20) @(negedge clk);
    check("long_stall_valid", out_valid, 1);
    check("long_stall_data", out_data, 19);
    check("long_stall_stable", out_data, first_val);
    #2 rst = 1'b1;
    #1;
    check("drain_rst_out_valid", out_valid, 0);
    check("drain_rst_out_last", out_last, 0);
    check("drain_rst_mm_cen", mm_cen, 0);
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    run2(vecs[1].a, vecs[1].b, vecs[1].c, 1'b0, "after_drain_rst");

    // N=4 identity case
    run4();

`ifdef MAT_MUL_SEQ_OVERLAP_EN
    overlap2();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
